// File: rtl/hps_cmd_fifo_if.sv
// Bus bundle for hps_cmd_fifo: Avalon-MM push slave, CSR slave,
// irq line and first-word-fall-through output stream.
// master: the bench/system side; slave: the FIFO side.
interface hps_cmd_fifo_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] in_writedata;
   logic              in_write;
   logic              in_address;
   logic              in_waitrequest;
   logic [2:0]        csr_address;
   logic              csr_read;
   logic              csr_write;
   logic [31:0]       csr_writedata;
   logic [31:0]       csr_readdata;
   logic              irq;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_writedata, in_write, in_address,
      output csr_address, csr_read, csr_write, csr_writedata,
      output out_ready,
      input  in_waitrequest, csr_readdata, irq,
      input  out_data, out_valid
   );

   modport slave (
      input  in_writedata, in_write, in_address,
      input  csr_address, csr_read, csr_write, csr_writedata,
      input  out_ready,
      output in_waitrequest, csr_readdata, irq,
      output out_data, out_valid
   );
endinterface

// File: rtl/hps_cmd_fifo.sv
// Single-clock command FIFO: Avalon-MM push in, FWFT stream out, CSRs.
// Ports: clk, reset (sync, active high), bus (hps_cmd_fifo_if.slave).
module hps_cmd_fifo #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 256,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int AF_DEFAULT = DEPTH - 4,
   parameter int AE_DEFAULT = 2
) (
   input logic          clk,
   input logic          reset,
   hps_cmd_fifo_if.slave bus
);
   localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wptr, rptr;
   logic [ADDR_W:0]   fill;
   logic [ADDR_W:0]   af_thresh, ae_thresh;
   logic [3:0]        evt, irq_en;
   logic              irq_q;
   logic [31:0]       rdata, rd_mux;

   logic       full, empty, almost_full, almost_empty;
   logic       push, pop, flush;
   logic [3:0] status, w1c;
   logic       unused_ok;

   assign full         = (fill == FULL_LVL);
   assign empty        = (fill == '0);
   assign almost_full  = (fill >= af_thresh);
   assign almost_empty = (fill <= ae_thresh);
   assign status       = {almost_empty, almost_full, empty, full};

   assign push  = bus.in_write & ~full;
   assign pop   = ~empty & bus.out_ready;
   assign flush = bus.csr_write & (bus.csr_address == 3'd6)
                & bus.csr_writedata[0];
   assign w1c   = (bus.csr_write && bus.csr_address == 3'd2)
                ? bus.csr_writedata[3:0] : 4'd0;

   assign bus.in_waitrequest = full;
   assign bus.out_valid      = ~empty;
   assign bus.out_data       = mem[rptr];
   assign bus.csr_readdata   = rdata;
   assign bus.irq            = irq_q;

   // in_address only exists for map compatibility
   assign unused_ok = ^{bus.in_address, bus.csr_writedata};

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= bus.in_writedata;
   end

   // flush beats any same-cycle push/pop
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr <= '0;
         rptr <= '0;
         fill <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fill <= fill + FILL_ONE;
            2'b01:   fill <= fill - FILL_ONE;
            default: fill <= fill;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.csr_address)
         3'd0:    rd_mux = 32'(fill);
         3'd1:    rd_mux = {28'd0, status};
         3'd2:    rd_mux = {28'd0, evt};
         3'd3:    rd_mux = {28'd0, irq_en};
         3'd4:    rd_mux = 32'(af_thresh);
         3'd5:    rd_mux = 32'(ae_thresh);
         default: rd_mux = '0;
      endcase
   end

   // event set wins over write-1-to-clear
   always_ff @(posedge clk) begin
      if (reset) begin
         evt       <= '0;
         irq_en    <= '0;
         irq_q     <= 1'b0;
         af_thresh <= (ADDR_W+1)'(AF_DEFAULT);
         ae_thresh <= (ADDR_W+1)'(AE_DEFAULT);
         rdata     <= '0;
      end else begin
         evt   <= (evt & ~w1c) | status;
         irq_q <= |(evt & irq_en);
         if (bus.csr_write) begin
            case (bus.csr_address)
               3'd3:    irq_en    <= bus.csr_writedata[3:0];
               3'd4:    af_thresh <= bus.csr_writedata[ADDR_W:0];
               3'd5:    ae_thresh <= bus.csr_writedata[ADDR_W:0];
               default: ;
            endcase
         end
         if (bus.csr_read) rdata <= rd_mux;
      end
   end
endmodule
